// File: rtl/pt_dec_if.sv
// pt_dec_if: bundles the OOK input line and the decoded word outputs of pt_dec.
// The master side drives din and observes data/valid/error; the slave side is the decoder.
interface pt_dec_if;
    logic        din;
    logic [23:0] data;
    logic        valid;
    logic        error;

    modport master (
        output din,
        input  data,
        input  valid,
        input  error
    );

    modport slave (
        input  din,
        output data,
        output valid,
        output error
    );
endinterface

// File: rtl/pt_dec.sv
// pt_dec: PT2262-style OOK receiver. Oversamples din, measures high/low segment
// widths, classifies pulses as 0 (short-high/long-low) or 1 (long-high/short-low)
// and assembles 24 pulses plus a sync gap into a 24-bit word, MSB first.
// Optional feature macro: PT_DEC_CONFIRM_EN -- report a frame only when it repeats
// the previously accepted frame (double-receive qualification).
// ALPHA_CYCLES is the number of clk cycles per encoder oscillator period; it must be >= 2.
module pt_dec #(
    parameter int ALPHA_CYCLES = 4
) (
    input  logic    clk,
    input  logic    rst,
    pt_dec_if.slave bus
);

    localparam int A  = ALPHA_CYCLES;
    localparam int CW = $clog2(64 * A + 2);

    localparam logic [CW-1:0] SHORT_MIN  = CW'(2 * A);
    localparam logic [CW-1:0] SHORT_MAX  = CW'(6 * A);
    localparam logic [CW-1:0] LONG_MIN   = CW'(8 * A);
    localparam logic [CW-1:0] LONG_MAX   = CW'(16 * A);
    localparam logic [CW-1:0] HIGH_LIMIT = CW'(17 * A);
    localparam logic [CW-1:0] GAP_LEN    = CW'(64 * A);
    localparam logic [CW-1:0] CNT_SAT    = CW'(64 * A + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [4:0]    FULL_BITS  = 5'd24;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Input synchronizer: two flops, chained through sync_chain.
    // ------------------------------------------------------------------
    logic [2:0] sync_chain;
    assign sync_chain[0] = bus.din;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic stage_reg;
            // One synchronizer stage, cleared by reset.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= sync_chain[gi];
                end
            end
            assign sync_chain[gi+1] = stage_reg;
        end
    endgenerate

    logic din_s;
    logic din_d_reg;
    assign din_s = sync_chain[2];

    // Delayed copy of the synchronized line for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            din_d_reg <= 1'b0;
        end else begin
            din_d_reg <= din_s;
        end
    end

    logic rise;
    assign rise = din_s & ~din_d_reg;

    // ------------------------------------------------------------------
    // Segment width counters. hcnt holds the last high width through the
    // following low, so both widths of a pulse are present at its ending
    // rising edge.
    // ------------------------------------------------------------------
    logic [CW-1:0] hcnt_reg;
    logic [CW-1:0] lcnt_reg;

    // Saturating high/low counters, restarted at 1 on the opening edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt_reg <= '0;
            lcnt_reg <= '0;
        end else if (din_s) begin
            if (!din_d_reg) begin
                hcnt_reg <= CNT_ONE;
            end else if (hcnt_reg != CNT_SAT) begin
                hcnt_reg <= hcnt_reg + CNT_ONE;
            end
        end else begin
            if (din_d_reg) begin
                lcnt_reg <= CNT_ONE;
            end else if (lcnt_reg != CNT_SAT) begin
                lcnt_reg <= lcnt_reg + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment classification
    // ------------------------------------------------------------------
    logic h_short, h_long, l_short, l_long, l_mid;
    logic bit_ok, bit_val;
    logic gap, high_over, rise_data;
    logic [4:0] bitcnt_reg;
    logic fault;

    assign h_short   = (hcnt_reg >= SHORT_MIN) && (hcnt_reg <= SHORT_MAX);
    assign h_long    = (hcnt_reg >= LONG_MIN)  && (hcnt_reg <= LONG_MAX);
    assign l_short   = (lcnt_reg >= SHORT_MIN) && (lcnt_reg <= SHORT_MAX);
    assign l_long    = (lcnt_reg >= LONG_MIN)  && (lcnt_reg <= LONG_MAX);
    assign l_mid     = (lcnt_reg > LONG_MAX)   && (lcnt_reg < GAP_LEN);
    assign bit_ok    = (h_short && l_long) || (h_long && l_short);
    assign bit_val   = h_long;

    // lcnt only sits at exactly GAP_LEN for one low-sampled cycle because it
    // saturates one above, so the gap fires once per low segment.
    assign gap       = !din_d_reg && (lcnt_reg == GAP_LEN);
    // Same trick for the over-long high: fires once, while the high is counted.
    assign high_over = din_d_reg && (hcnt_reg == HIGH_LIMIT);
    // A rising edge that ends an ordinary (non-gap) low closes a pulse.
    assign rise_data = rise && (lcnt_reg < GAP_LEN);

    // Conditions that abandon the current frame and drop back to HUNT.
    assign fault = (state_reg == FRAME) && !gap &&
                   (high_over ||
                    (rise_data && (l_mid ||
                                   ((bitcnt_reg == FULL_BITS) ? !h_short : !bit_ok))));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a sync gap opens a frame, a fault abandons it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HUNT:    if (gap)   state_next = FRAME;
            FRAME:   if (fault) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    logic shift_en, bitcnt_clr, accept_en, error_next;

    // Output/event logic for the datapath and the registered strobes.
    always_comb begin
        shift_en   = 1'b0;
        bitcnt_clr = 1'b0;
        accept_en  = 1'b0;
        error_next = 1'b0;
        case (state_reg)
            HUNT: begin
                bitcnt_clr = gap;
            end
            FRAME: begin
                if (gap) begin
                    bitcnt_clr = 1'b1;
                    accept_en  = (bitcnt_reg == FULL_BITS);
                    error_next = (bitcnt_reg != 5'd0) && (bitcnt_reg != FULL_BITS);
                end else if (fault) begin
                    error_next = 1'b1;
                end else if (rise_data && (bitcnt_reg != FULL_BITS)) begin
                    shift_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [23:0] shreg_reg;
    logic        error_reg;

    // Bit counter, shift register and the error strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bitcnt_reg <= 5'd0;
            shreg_reg  <= '0;
            error_reg  <= 1'b0;
        end else begin
            if (bitcnt_clr) begin
                bitcnt_reg <= 5'd0;
            end else if (shift_en) begin
                bitcnt_reg <= bitcnt_reg + 5'd1;
            end
            if (shift_en) begin
                shreg_reg <= {shreg_reg[22:0], bit_val};
            end
            error_reg <= error_next;
        end
    end

    logic [23:0] data_reg;
    logic        valid_reg;

`ifdef PT_DEC_CONFIRM_EN
    logic [23:0] cmp_reg;
    logic        cmp_loaded_reg;

    // Accept only a frame that repeats the previous one; errors forget it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            cmp_reg        <= '0;
            cmp_loaded_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (accept_en) begin
                if (cmp_loaded_reg && (cmp_reg == shreg_reg)) begin
                    data_reg  <= shreg_reg;
                    valid_reg <= 1'b1;
                end else begin
                    cmp_reg        <= shreg_reg;
                    cmp_loaded_reg <= 1'b1;
                end
            end else if (error_next) begin
                cmp_loaded_reg <= 1'b0;
            end
        end
    end
`else
    // Every complete frame is published at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= accept_en;
            if (accept_en) begin
                data_reg <= shreg_reg;
            end
        end
    end
`endif

    assign bus.data  = data_reg;
    assign bus.valid = valid_reg;
    assign bus.error = error_reg;

endmodule
